dtc_tree_sched: RTL and testbench

DTC_TREE_SCHED -- requirements
Module: dtc_tree_sched

---
 rtl/dtc_sched_pkg.sv | 25 ++
 rtl/dtc_tree_core.sv | 16 +
 rtl/dtc_tree_sched.sv | 133 +++++++++++++
 tb/tb_dtc_tree_sched.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/dtc_sched_pkg.sv
// Shared widths, FSM state encoding and helpers for the classifier scheduler.
package dtc_sched_pkg;

    localparam int NREQ    = 4;
    localparam int FEAT_W  = 7;
    localparam int CODE_W  = 7;
    localparam int ID_W    = 2;
    localparam int CLASS_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        HOLD = 2'd2
    } sched_state_e;

    function automatic logic [CLASS_W-1:0] popcount_code(input logic [CODE_W-1:0] code);
        logic [CLASS_W-1:0] n;
        n = '0;
        for (int k = 0; k < CODE_W; k++) begin
            n = n + CLASS_W'(code[k]);
        end
        return n;
    endfunction

endpackage

// File: rtl/dtc_tree_core.sv
// Combinational threshold-tree classifier: one comparator node per code bit,
// producing a thermometer code (7'h00 -> 7'h7F, 7'h01 -> 7'h3F, 7'h7F -> 7'h00).
module dtc_tree_core
    import dtc_sched_pkg::*;
(
    input  logic [FEAT_W-1:0] feat_i,
    output logic [CODE_W-1:0] code_o
);

    // Node k fires when the feature is below 2^(6-k); thresholds shrink with k,
    // so the set bits always form a contiguous run from bit 0.
    for (genvar k = 0; k < CODE_W; k++) begin : g_node
        assign code_o[k] = ({1'b0, feat_i} < 8'(1 << (CODE_W - 1 - k)));
    end

endmodule

// File: rtl/dtc_tree_sched.sv
// Round-robin scheduler sharing one dtc_tree_core among NREQ requesters.
// Optional res_class output (popcount of res_code) enabled by DTC_TREE_SCHED_CLASS_EN.
module dtc_tree_sched
    import dtc_sched_pkg::*;
#(
    parameter int NREQ = dtc_sched_pkg::NREQ
)(
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*FEAT_W-1:0] req_data,
    output logic [NREQ-1:0]        req_ready,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [ID_W-1:0]        res_id,
    output logic [CODE_W-1:0]      res_code,
    output logic                   busy
`ifdef DTC_TREE_SCHED_CLASS_EN
    ,
    output logic [CLASS_W-1:0]     res_class
`endif
);

    sched_state_e      state_q, state_d;
    logic [ID_W-1:0]   last_grant_q;
    logic [FEAT_W-1:0] feat_q;
    logic [ID_W-1:0]   id_q;
    logic [CODE_W-1:0] res_code_q;
    logic [ID_W-1:0]   res_id_q;
    logic              res_valid_q;

    logic [ID_W-1:0]   cand;
    logic [ID_W-1:0]   grant_idx;
    logic              grant_found;
    logic              accept;
    logic [CODE_W-1:0] core_code;

    // Round-robin search starting just after the last winner; the ID-width
    // addition wraps modulo 4 naturally.
    always_comb begin
        cand        = '0;
        grant_idx   = '0;
        grant_found = 1'b0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = last_grant_q + ID_W'(i);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        accept    = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_found) begin
                    req_ready[grant_idx] = 1'b1;
                    accept               = 1'b1;
                    state_d              = EVAL;
                end
            end
            EVAL: state_d = HOLD;
            HOLD: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    dtc_tree_core u_core (
        .feat_i (feat_q),
        .code_o (core_code)
    );

    // Request capture at accept; the result registers are only written in EVAL,
    // so they stay frozen through HOLD regardless of requester activity.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_q <= ID_W'(NREQ - 1);
            feat_q       <= '0;
            id_q         <= '0;
            res_code_q   <= '0;
            res_id_q     <= '0;
            res_valid_q  <= 1'b0;
        end else begin
            if (accept) begin
                feat_q       <= req_data[int'(grant_idx)*FEAT_W +: FEAT_W];
                id_q         <= grant_idx;
                last_grant_q <= grant_idx;
            end
            if (state_q == EVAL) begin
                res_code_q  <= core_code;
                res_id_q    <= id_q;
                res_valid_q <= 1'b1;
            end else if (state_q == HOLD && res_ready) begin
                res_valid_q <= 1'b0;
            end
        end
    end

`ifdef DTC_TREE_SCHED_CLASS_EN
    logic [CLASS_W-1:0] res_class_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_class_q <= '0;
        end else if (state_q == EVAL) begin
            res_class_q <= popcount_code(core_code);
        end
    end

    assign res_class = res_class_q;
`endif

    assign res_valid = res_valid_q;
    assign res_code  = res_code_q;
    assign res_id    = res_id_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_dtc_tree_sched.sv
// Directed self-checking bench for dtc_tree_sched; define DTC_TREE_SCHED_CLASS_EN
// to also check res_class.
module tb_dtc_tree_sched;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [27:0] req_data;
    logic [3:0]  req_ready;
    logic        res_valid;
    logic        res_ready;
    logic [1:0]  res_id;
    logic [6:0]  res_code;
    logic        busy;
`ifdef DTC_TREE_SCHED_CLASS_EN
    logic [2:0]  res_class;
`endif

    int nTests = 0;
    int nFail  = 0;

    dtc_tree_sched #(.NREQ(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_id    (res_id),
        .res_code  (res_code),
        .busy      (busy)
`ifdef DTC_TREE_SCHED_CLASS_EN
        ,
        .res_class (res_class)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nTests++;
        if (obs !== exp) begin
            nFail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] v, input logic [27:0] d, input logic rr);
        req_valid = v;
        req_data  = d;
        res_ready = rr;
    endtask

    // Advance one cycle: drive just after the rising edge, sample on the falling edge.
    task automatic step(input logic [3:0] v, input logic [27:0] d, input logic rr);
        @(posedge clk);
        #1;
        applyStimulus(v, d, rr);
        @(negedge clk);
    endtask

    task automatic doReset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        applyStimulus(4'b0, 28'h0, 1'b1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic [27:0] rrData;
    logic [1:0]  rrId   [5];
    logic [6:0]  rrCode [4];

    initial begin
        rst = 1'b1;
        applyStimulus(4'b0, 28'h0, 1'b1);
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst_valid", 32'(res_valid), 32'd0);
        checkOutput("rst_code",  32'(res_code),  32'h00);
        checkOutput("rst_id",    32'(res_id),    32'd0);
        checkOutput("rst_ready", 32'(req_ready), 32'd0);
        checkOutput("rst_busy",  32'(busy),      32'd0);
`ifdef DTC_TREE_SCHED_CLASS_EN
        checkOutput("rst_class", 32'(res_class), 32'd0);
`endif
        rst = 1'b0;

        // Single request from requester 0, feature 7'h00.
        step(4'b0001, 28'h0, 1'b1);
        checkOutput("single_ready", 32'(req_ready), 32'b0001);
        checkOutput("single_idle",  32'(busy),      32'd0);
        step(4'b0000, 28'h0, 1'b1);
        checkOutput("single_eval_ready", 32'(req_ready), 32'd0);
        checkOutput("single_eval_busy",  32'(busy),      32'd1);
        checkOutput("single_eval_valid", 32'(res_valid), 32'd0);
        step(4'b0000, 28'h0, 1'b1);
        checkOutput("single_valid", 32'(res_valid), 32'd1);
        checkOutput("single_code",  32'(res_code),  32'h7F);
        checkOutput("single_id",    32'(res_id),    32'd0);
        step(4'b0000, 28'h0, 1'b1);
        checkOutput("single_done_valid", 32'(res_valid), 32'd0);
        checkOutput("single_done_busy",  32'(busy),      32'd0);

        // Round robin from reset: requesters 3..0 carry 03, 40, 10, 05.
        doReset();
        rrData = {7'h03, 7'h40, 7'h10, 7'h05};
        rrId   = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        rrCode = '{7'h0F, 7'h03, 7'h00, 7'h1F};
        for (int g = 0; g < 5; g++) begin
            step(4'hF, rrData, 1'b1);
            checkOutput($sformatf("rr%0d_ready", g), 32'(req_ready), 32'(4'b0001 << rrId[g]));
            step(4'hF, rrData, 1'b1);
            checkOutput($sformatf("rr%0d_eval_ready", g), 32'(req_ready), 32'd0);
            step(4'hF, rrData, 1'b1);
            checkOutput($sformatf("rr%0d_valid", g), 32'(res_valid), 32'd1);
            checkOutput($sformatf("rr%0d_id", g),    32'(res_id),    32'(rrId[g]));
            checkOutput($sformatf("rr%0d_code", g),  32'(res_code),  32'(rrCode[rrId[g]]));
        end

        // Backpressure: last grant was 0, only requester 3 (7'h20 -> 7'h01) valid.
        step(4'b1000, {7'h20, 21'h0}, 1'b0);
        checkOutput("bp_ready", 32'(req_ready), 32'b1000);
        step(4'b1000, {7'h20, 21'h0}, 1'b0);
        checkOutput("bp_eval_ready", 32'(req_ready), 32'd0);
        for (int c = 0; c < 5; c++) begin
            step(4'b1000, {7'h20, 21'h0}, 1'b0);
            checkOutput($sformatf("bp%0d_valid", c), 32'(res_valid), 32'd1);
            checkOutput($sformatf("bp%0d_code", c),  32'(res_code),  32'h01);
            checkOutput($sformatf("bp%0d_id", c),    32'(res_id),    32'd3);
            checkOutput($sformatf("bp%0d_ready", c), 32'(req_ready), 32'd0);
        end
        step(4'b1000, {7'h20, 21'h0}, 1'b1);
        checkOutput("bp_hs_valid", 32'(res_valid), 32'd1);
        checkOutput("bp_hs_ready", 32'(req_ready), 32'd0);
        step(4'b1000, {7'h20, 21'h0}, 1'b0);
        checkOutput("bp_idle_valid", 32'(res_valid), 32'd0);
        checkOutput("bp_idle_busy",  32'(busy),      32'd0);
        checkOutput("bp_regrant",    32'(req_ready), 32'b1000);
        step(4'b0000, 28'h0, 1'b0);
        step(4'b0000, 28'h0, 1'b0);
        checkOutput("hold2_valid", 32'(res_valid), 32'd1);

        // Reset while holding a result.
        #1 rst = 1'b1;
        #1;
        checkOutput("mid_rst_valid", 32'(res_valid), 32'd0);
        checkOutput("mid_rst_busy",  32'(busy),      32'd0);
        checkOutput("mid_rst_code",  32'(res_code),  32'h00);
        #1 rst = 1'b0;
        step(4'b1001, {7'h00, 14'h0, 7'h01}, 1'b1);
        checkOutput("post_rst_ready", 32'(req_ready), 32'b0001);
        step(4'b0000, 28'h0, 1'b1);
        step(4'b0000, 28'h0, 1'b1);
        checkOutput("post_rst_id",   32'(res_id),   32'd0);
        checkOutput("post_rst_code", 32'(res_code), 32'h3F);
`ifdef DTC_TREE_SCHED_CLASS_EN
        checkOutput("post_rst_class", 32'(res_class), 32'd6);
`endif

        // Data change after accept: requester 2 sends 7'h7F then switches to 7'h01.
        step(4'b0100, {7'h00, 7'h7F, 14'h0}, 1'b1);
        checkOutput("dc_ready", 32'(req_ready), 32'b0100);
        step(4'b0100, {7'h00, 7'h01, 14'h0}, 1'b1);
        checkOutput("dc_eval_ready", 32'(req_ready), 32'd0);
        step(4'b0000, {7'h00, 7'h01, 14'h0}, 1'b1);
        checkOutput("dc_valid", 32'(res_valid), 32'd1);
        checkOutput("dc_code",  32'(res_code),  32'h00);
        checkOutput("dc_id",    32'(res_id),    32'd2);
        step(4'b0000, 28'h0, 1'b1);
        checkOutput("dc_done_busy", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
